// File: rtl/fetch_pkg.sv
// Shared FSM encoding, AXI constants and helpers for the burst stream reader.
package fetch_pkg;

  typedef enum logic [2:0] {IDLE, CALC, ADDR, DATA, DRAIN} fetch_state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam int         BOUNDARY_4K = 4096;

  function automatic int clog2_bytes(input int width);
    return $clog2(width / 8);
  endfunction

endpackage

// File: rtl/fetch_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; the head word
// is read straight out of storage so rd_data is valid whenever empty is low.
module fetch_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = rd_en && !empty;
  // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
  assign do_push = wr_en && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(wr_en && full && !rd_en));
  end

endmodule

// File: rtl/axi_burst_stream_reader.sv
// AXI4 read master: splits a beat-count request into 4 KB-safe bursts and streams the data on AXIS.
// Optional build macro FETCH_ERR_ABORT_EN stops issuing bursts after the first read error.
module axi_burst_stream_reader
  import fetch_pkg::*;
#(
  parameter int C_M_AXI_ID_WIDTH   = 8,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_MAX_BURST_LEN    = 16,
  parameter int C_FIFO_DEPTH       = 32,
  parameter int C_LEN_WIDTH        = 20
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_areset,
  input  logic                          start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] start_addr,
  input  logic [C_LEN_WIDTH-1:0]        xfer_beats,
  output logic                          busy,
  output logic                          done,
  output logic                          rd_err,
  output logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_arid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arlock,
  output logic [3:0]                    m_axi_arcache,
  output logic [2:0]                    m_axi_arprot,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_M_AXI_ID_WIDTH-1:0]   m_axi_rid,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready
);

  localparam int BYTES_LOG = clog2_bytes(C_M_AXI_DATA_WIDTH);
  localparam int CNT_W     = $clog2(C_FIFO_DEPTH) + 1;

  fetch_state_t                  state, state_next;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr;
  logic [C_LEN_WIDTH-1:0]        remaining;
  logic [C_LEN_WIDTH-1:0]        pop_left;
  logic [C_LEN_WIDTH-1:0]        trim;
  logic [8:0]                    blen, blen_m1, calc_blen, owed;
  logic [CNT_W-1:0]              fifo_count;
  logic                          fifo_empty, fifo_full;
  logic                          ar_hs, r_hs, r_err, r_last_hs, pop, last_pop;
  logic                          credit_ok, stop_fetch;
  logic [31:0]                   to_boundary, cap, free_slots;
  logic                          unused_ok;

  assign m_axi_arid    = '0;
  assign m_axi_arsize  = 3'(BYTES_LOG);
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;

  assign ar_hs         = m_axi_arvalid && m_axi_arready;
  assign m_axi_rready  = (state == DATA);
  assign r_hs          = m_axi_rvalid && m_axi_rready;
  assign r_err         = r_hs && (m_axi_rresp != RESP_OKAY);
  assign r_last_hs     = r_hs && m_axi_rlast;
  assign m_axis_tvalid = !fifo_empty;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tlast  = m_axis_tvalid && (pop_left == C_LEN_WIDTH'(1));
  assign last_pop      = (state == DRAIN) && pop && (fifo_count == CNT_W'(1));
  assign blen_m1       = blen - 9'd1;
  assign unused_ok     = ^{m_axi_rid, fifo_full, blen_m1[8]};

`ifdef FETCH_ERR_ABORT_EN
  // After an error, let the burst in flight finish and fetch nothing more.
  assign stop_fetch = rd_err || r_err;
`else
  assign stop_fetch = 1'b0;
`endif

  // Beats not fetched because of an abort are removed from the tlast countdown.
  assign trim = (r_last_hs && stop_fetch) ? remaining : '0;

  always_comb begin
    to_boundary = (32'(BOUNDARY_4K) - 32'(addr[11:0])) >> BYTES_LOG;
    cap = 32'(C_MAX_BURST_LEN);
    if (32'(remaining) < cap) cap = 32'(remaining);
    if (to_boundary < cap)    cap = to_boundary;
    calc_blen  = 9'(cap);
    free_slots = 32'(C_FIFO_DEPTH) - 32'(fifo_count);
    credit_ok  = (32'(owed) + 32'(blen)) <= free_slots;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && xfer_beats != '0) state_next = CALC;
      CALC:    state_next = ADDR;
      ADDR:    if (ar_hs) state_next = DATA;
      DATA:    if (r_last_hs) state_next = (remaining != '0 && !stop_fetch) ? CALC : DRAIN;
      DRAIN:   if (last_pop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) state <= IDLE;
    else              state <= state_next;
  end

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      addr          <= '0;
      remaining     <= '0;
      pop_left      <= '0;
      blen          <= '0;
      owed          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rd_err        <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        if (xfer_beats == '0) begin
          done <= 1'b1;
        end else begin
          addr      <= start_addr;
          remaining <= xfer_beats;
          pop_left  <= xfer_beats;
          rd_err    <= 1'b0;
          busy      <= 1'b1;
        end
      end else begin
        pop_left <= pop_left - C_LEN_WIDTH'(pop) - trim;
      end
      if (state == CALC) blen <= calc_blen;
      // AR fields are captured once and held until the slave accepts them.
      if (state == ADDR && !m_axi_arvalid && credit_ok) begin
        m_axi_arvalid <= 1'b1;
        m_axi_araddr  <= addr;
        m_axi_arlen   <= blen_m1[7:0];
      end
      if (ar_hs) begin
        m_axi_arvalid <= 1'b0;
        addr          <= addr + (C_M_AXI_ADDR_WIDTH'(blen) << BYTES_LOG);
        remaining     <= remaining - C_LEN_WIDTH'(blen);
        owed          <= blen;
      end
      if (r_hs)  owed   <= r_last_hs ? 9'd0 : owed - 9'd1;
      if (r_err) rd_err <= 1'b1;
      if (last_pop) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

  fetch_sync_fifo #(
    .WIDTH (C_M_AXI_DATA_WIDTH),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk     (m_axi_aclk),
    .reset   (m_axi_areset),
    .wr_en   (r_hs),
    .wr_data (m_axi_rdata),
    .rd_en   (pop),
    .rd_data (m_axis_tdata),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_axi_burst_stream_reader.sv
// Directed bench for axi_burst_stream_reader: a simple AXI read slave returns
// each beat's address as data; AR, AXIS and done activity are logged and checked.
module tb_axi_burst_stream_reader;

  logic        clk = 1'b0;
  logic        areset;
  logic        start;
  logic [31:0] start_addr;
  logic [19:0] xfer_beats;
  logic        busy, done, rd_err;
  logic [7:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [7:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [31:0] tdata;
  logic        tvalid, tlast, tready;

  int tests_run = 0;
  int tests_failed = 0;

  int cyc = 0;
  int done_cnt, done_cyc, last_cyc, r_count, r_total;
  int err_idx = -1;
  bit busy_seen;

  logic [31:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];
  logic [31:0] ax_data_q[$];
  bit          ax_last_q[$];
  logic [31:0] exp_addr_q[$];
  logic [7:0]  exp_len_q[$];

  logic [31:0] sq_addr[$];
  logic [7:0]  sq_len[$];
  bit          r_active;
  logic [31:0] r_addr;
  int          r_idx, r_len;
  bit          rst_s, ar_hs_s, r_hs_s, t_hs_s;

  always #5 clk = ~clk;

  axi_burst_stream_reader dut (
    .m_axi_aclk    (clk),
    .m_axi_areset  (areset),
    .start         (start),
    .start_addr    (start_addr),
    .xfer_beats    (xfer_beats),
    .busy          (busy),
    .done          (done),
    .rd_err        (rd_err),
    .m_axi_arid    (arid),
    .m_axi_araddr  (araddr),
    .m_axi_arlen   (arlen),
    .m_axi_arsize  (arsize),
    .m_axi_arburst (arburst),
    .m_axi_arlock  (arlock),
    .m_axi_arcache (arcache),
    .m_axi_arprot  (arprot),
    .m_axi_arvalid (arvalid),
    .m_axi_arready (arready),
    .m_axi_rid     (rid),
    .m_axi_rdata   (rdata),
    .m_axi_rresp   (rresp),
    .m_axi_rlast   (rlast),
    .m_axi_rvalid  (rvalid),
    .m_axi_rready  (rready),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tlast  (tlast),
    .m_axis_tready (tready)
  );

  // Monitors sample on the falling edge; the slave updates its outputs just after the rising edge.
  initial begin
    rvalid = 1'b0; rdata = '0; rlast = 1'b0; rresp = 2'b00;
    r_active = 1'b0; r_addr = '0; r_idx = 0; r_len = 0;
    forever begin
      @(negedge clk);
      rst_s   = areset;
      ar_hs_s = arvalid && arready;
      r_hs_s  = rvalid && rready;
      t_hs_s  = tvalid && tready;
      if (!rst_s) begin
        if (ar_hs_s) begin ar_addr_q.push_back(araddr); ar_len_q.push_back(arlen); end
        if (t_hs_s) begin
          ax_data_q.push_back(tdata);
          ax_last_q.push_back(tlast);
          if (tlast) last_cyc = cyc;
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (busy) busy_seen = 1'b1;
        if (r_hs_s) r_count++;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (rst_s) begin
        sq_addr.delete(); sq_len.delete(); r_active = 1'b0;
      end else begin
        if (ar_hs_s) begin sq_addr.push_back(araddr); sq_len.push_back(arlen); end
        if (r_hs_s) begin
          r_total++;
          if (r_idx == r_len) r_active = 1'b0;
          else begin r_idx++; r_addr = r_addr + 32'd4; end
        end
        if (!r_active && sq_addr.size() > 0) begin
          r_addr = sq_addr.pop_front();
          r_len  = int'(sq_len.pop_front());
          r_idx  = 0;
          r_active = 1'b1;
        end
      end
      rvalid = r_active;
      rdata  = r_addr;
      rlast  = r_active && (r_idx == r_len);
      rresp  = (r_active && r_total == err_idx) ? 2'b10 : 2'b00;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [19:0] beats);
    start_addr = addr;
    xfer_beats = beats;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic clearLogs();
    ar_addr_q.delete(); ar_len_q.delete();
    ax_data_q.delete(); ax_last_q.delete();
    done_cnt = 0; done_cyc = -1; last_cyc = -1;
    r_count = 0; r_total = 0; busy_seen = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic waitDone(input string tag, input int max_cycles);
    int n = 0;
    while (done_cnt == 0 && n < max_cycles) begin @(posedge clk); #1; n++; end
    checkOutput({tag, "_done_seen"}, 64'(done_cnt > 0), 64'd1);
    waitCycles(4);
  endtask

  task automatic checkTransfer(input string tag, input logic [31:0] base, input int nbeats);
    checkOutput({tag, "_ar_count"}, 64'(ar_addr_q.size()), 64'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size() && i < ar_addr_q.size(); i++) begin
      checkOutput({tag, "_araddr"}, 64'(ar_addr_q[i]), 64'(exp_addr_q[i]));
      checkOutput({tag, "_arlen"}, 64'(ar_len_q[i]), 64'(exp_len_q[i]));
    end
    checkOutput({tag, "_beats"}, 64'(ax_data_q.size()), 64'(nbeats));
    for (int i = 0; i < ax_data_q.size(); i++) begin
      checkOutput({tag, "_tdata"}, 64'(ax_data_q[i]), 64'(base + 32'(4 * i)));
      checkOutput({tag, "_tlast"}, 64'(ax_last_q[i]), 64'(i == nbeats - 1));
    end
    checkOutput({tag, "_done_count"}, 64'(done_cnt), 64'd1);
    checkOutput({tag, "_done_timing"}, 64'(done_cyc), 64'(last_cyc + 1));
    exp_addr_q.delete(); exp_len_q.delete();
  endtask

  initial begin
    int n;
    areset = 1'b1; start = 1'b0; start_addr = '0; xfer_beats = '0;
    tready = 1'b1; arready = 1'b1; rid = '0;
    clearLogs();
    waitCycles(4);
    areset = 1'b0;
    @(negedge clk);
    checkOutput("rst_arvalid", 64'(arvalid), 64'd0);
    checkOutput("rst_arsize", 64'(arsize), 64'd2);
    checkOutput("rst_arburst", 64'(arburst), 64'd1);
    checkOutput("rst_arcache", 64'(arcache), 64'd3);
    checkOutput("rst_busy_done_err", 64'({busy, done, rd_err}), 64'd0);
    checkOutput("rst_tvalid_rready", 64'({tvalid, rready}), 64'd0);
    @(posedge clk); #1;

    // Three bursts, with a start during busy that must be ignored
    clearLogs();
    applyStimulus(32'h0000_0000, 20'd40);
    waitCycles(5);
    applyStimulus(32'h0000_5000, 20'd8);
    waitDone("t1", 2000);
    exp_addr_q = '{32'h0, 32'h40, 32'h80};
    exp_len_q  = '{8'd15, 8'd15, 8'd7};
    checkTransfer("t1", 32'h0, 40);

    // Split at the 4 KB boundary
    clearLogs();
    applyStimulus(32'h0000_0FF8, 20'd4);
    waitDone("t2", 500);
    exp_addr_q = '{32'hFF8, 32'h1000};
    exp_len_q  = '{8'd1, 8'd1};
    checkTransfer("t2", 32'hFF8, 4);

    // Back-pressure: AR issue stalls at the FIFO credit limit
    clearLogs();
    applyStimulus(32'h0000_2000, 20'd64);
    n = 0;
    while (ax_data_q.size() == 0 && n < 200) begin @(posedge clk); #1; n++; end
    tready = 1'b0;
    waitCycles(50);
    checkOutput("t3_stall_beats", 64'(ax_data_q.size()), 64'd1);
    checkOutput("t3_stall_ars", 64'(ar_addr_q.size()), 64'd2);
    checkOutput("t3_stall_rbeats", 64'(r_count), 64'd32);
    tready = 1'b1;
    waitDone("t3", 2000);
    exp_addr_q = '{32'h2000, 32'h2040, 32'h2080, 32'h20C0};
    exp_len_q  = '{8'd15, 8'd15, 8'd15, 8'd15};
    checkTransfer("t3", 32'h2000, 64);

    // SLVERR on the fifth beat
    clearLogs();
    err_idx = 4;
    applyStimulus(32'h0000_3000, 20'd32);
    waitDone("t4", 2000);
    err_idx = -1;
    checkOutput("t4_rd_err", 64'(rd_err), 64'd1);
`ifdef FETCH_ERR_ABORT_EN
    exp_addr_q = '{32'h3000};
    exp_len_q  = '{8'd15};
    checkTransfer("t4", 32'h3000, 16);
`else
    exp_addr_q = '{32'h3000, 32'h3040};
    exp_len_q  = '{8'd15, 8'd15};
    checkTransfer("t4", 32'h3000, 32);
`endif

    // Zero-length request: done only, rd_err left alone
    clearLogs();
    applyStimulus(32'h0000_6000, 20'd0);
    waitCycles(6);
    checkOutput("t5_done_count", 64'(done_cnt), 64'd1);
    checkOutput("t5_ar_count", 64'(ar_addr_q.size()), 64'd0);
    checkOutput("t5_busy_seen", 64'(busy_seen), 64'd0);
    checkOutput("t5_rd_err_kept", 64'(rd_err), 64'd1);

    // Reset in the middle of a data phase, then a normal transfer
    clearLogs();
    applyStimulus(32'h0000_4000, 20'd32);
    n = 0;
    while (r_count < 5 && n < 200) begin @(posedge clk); #1; n++; end
    checkOutput("t6_data_started", 64'(r_count >= 5), 64'd1);
    areset = 1'b1;
    @(posedge clk); #1;
    areset = 1'b0;
    checkOutput("t6_arvalid", 64'(arvalid), 64'd0);
    checkOutput("t6_tvalid", 64'(tvalid), 64'd0);
    checkOutput("t6_busy", 64'(busy), 64'd0);
    checkOutput("t6_rready_err", 64'({rready, rd_err}), 64'd0);
    waitCycles(2);
    clearLogs();
    applyStimulus(32'h0000_0100, 20'd8);
    waitDone("t6", 500);
    exp_addr_q = '{32'h100};
    exp_len_q  = '{8'd7};
    checkTransfer("t6", 32'h100, 8);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got %0d cycles, expected completion", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
